// File: rtl/nanop_core.sv
// Accumulator micro-CPU: two-word instructions (opcode, operand address) run through
// a FETCH_I / FETCH_A / EXEC sequence over a single ready-handshaked memory port.
module nanop_core #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk_i,
  input  logic          reset_i,
  output logic [AW-1:0] mem_addr_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic [DW-1:0] mem_wdata_o,
  output logic          mem_rd_o,
  output logic          mem_wr_o,
  input  logic          mem_ready_i,
  output logic [DW-1:0] out_data_o,
  output logic          out_valid_o
);

  typedef enum logic [1:0] {FETCH_I, FETCH_A, EXEC} state_t;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0, OP_XOR = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
    OP_ADD = 4'd4, OP_ADC = 4'd5, OP_SUB = 4'd6, OP_SBC = 4'd7,
    OP_ROL = 4'd8, OP_ROR = 4'd9, OP_LDA = 4'd10, OP_STA = 4'd11,
    OP_OUT = 4'd12, OP_JMP = 4'd13, OP_JNC = 4'd14, OP_JNZ = 4'd15
  } op_t;

  state_t        state_q;
  op_t           ir_q;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] ar_q;
  logic [DW-1:0] acc_q;
  logic          c_q;
  logic          z_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          mem_rd_q;
  logic          mem_wr_q;
  logic [DW-1:0] out_data_q;
  logic          out_valid_q;

  logic [DW-1:0] acc_d;
  logic          c_d;
  logic          z_d;
  logic          acc_we;
  logic [DW:0]   sum_w;
  logic [DW:0]   diff_w;
  logic          cin_w;
  logic          bin_w;
  logic          take_w;
  logic          exec_done_w;
  logic [AW-1:0] pc_inc_w;
  logic [AW-1:0] pc_exec_w;

  // Instructions whose EXEC step touches memory (read operand or store).
  function automatic logic is_mem_op(input op_t op);
    case (op)
      OP_XOR, OP_AND, OP_OR, OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_LDA, OP_STA:
        is_mem_op = 1'b1;
      default:
        is_mem_op = 1'b0;
    endcase
  endfunction

  assign cin_w  = (ir_q == OP_ADC) ? c_q : 1'b0;
  assign bin_w  = (ir_q == OP_SBC) ? c_q : 1'b0;
  assign sum_w  = {1'b0, acc_q} + {1'b0, mem_rdata_i} + {{DW{1'b0}}, cin_w};
  // Bit DW of the widened difference is the borrow out.
  assign diff_w = {1'b0, acc_q} - {1'b0, mem_rdata_i} - {{DW{1'b0}}, bin_w};

  assign take_w = (ir_q == OP_JMP) ||
                  ((ir_q == OP_JNC) && !c_q) ||
                  ((ir_q == OP_JNZ) && !z_q);

  assign pc_inc_w    = pc_q + AW'(1);
  assign pc_exec_w   = take_w ? ar_q : pc_q;
  assign exec_done_w = !is_mem_op(ir_q) || mem_ready_i;

  always_comb begin
    acc_d  = acc_q;
    c_d    = c_q;
    acc_we = 1'b0;
    case (ir_q)
      OP_XOR: begin acc_d = acc_q ^ mem_rdata_i; acc_we = 1'b1; end
      OP_AND: begin acc_d = acc_q & mem_rdata_i; acc_we = 1'b1; end
      OP_OR:  begin acc_d = acc_q | mem_rdata_i; acc_we = 1'b1; end
      OP_LDA: begin acc_d = mem_rdata_i;         acc_we = 1'b1; end
      OP_ADD, OP_ADC: begin
        {c_d, acc_d} = sum_w;
        acc_we = 1'b1;
      end
      OP_SUB, OP_SBC: begin
        {c_d, acc_d} = diff_w;
        acc_we = 1'b1;
      end
      OP_ROL: begin
        acc_d  = {acc_q[DW-2:0], c_q};
        c_d    = acc_q[DW-1];
        acc_we = 1'b1;
      end
      OP_ROR: begin
        acc_d  = {c_q, acc_q[DW-1:1]};
        c_d    = acc_q[0];
        acc_we = 1'b1;
      end
      default: begin
        acc_d  = acc_q;
        c_d    = c_q;
        acc_we = 1'b0;
      end
    endcase
    z_d = acc_we ? (acc_d == '0) : z_q;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= FETCH_I;
      ir_q        <= OP_NOP;
      pc_q        <= '0;
      ar_q        <= '0;
      acc_q       <= '0;
      c_q         <= 1'b0;
      z_q         <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        FETCH_I: begin
          // The first cycle out of reset only raises the opcode read.
          if (!mem_rd_q) begin
            mem_rd_q   <= 1'b1;
            mem_addr_q <= pc_q;
          end else if (mem_ready_i) begin
            ir_q       <= op_t'(mem_rdata_i[3:0]);
            pc_q       <= pc_inc_w;
            mem_addr_q <= pc_inc_w;
            state_q    <= FETCH_A;
          end
        end
        FETCH_A: begin
          if (mem_ready_i) begin
            ar_q    <= mem_rdata_i[AW-1:0];
            pc_q    <= pc_inc_w;
            state_q <= EXEC;
            if (is_mem_op(ir_q)) begin
              mem_addr_q  <= mem_rdata_i[AW-1:0];
              mem_rd_q    <= (ir_q != OP_STA);
              mem_wr_q    <= (ir_q == OP_STA);
              mem_wdata_q <= acc_q;
            end else begin
              mem_rd_q <= 1'b0;
            end
          end
        end
        EXEC: begin
          if (exec_done_w) begin
            acc_q <= acc_d;
            c_q   <= c_d;
            z_q   <= z_d;
            if (ir_q == OP_OUT) begin
              out_data_q  <= acc_q;
              out_valid_q <= 1'b1;
            end
            pc_q       <= pc_exec_w;
            mem_addr_q <= pc_exec_w;
            mem_rd_q   <= 1'b1;
            mem_wr_q   <= 1'b0;
            state_q    <= FETCH_I;
          end
        end
        default: begin
          state_q  <= FETCH_I;
          mem_rd_q <= 1'b0;
          mem_wr_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_rd_o    = mem_rd_q;
  assign mem_wr_o    = mem_wr_q;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_nanop_core.sv
// Self-checking bench for nanop_core: a behavioural memory, OUT/write scoreboards
// and directed programs for the ALU, flags, branches, wait states, PC wrap and reset.
module tb_nanop_core;
  localparam int DW = 8;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] mem_wdata;
  logic          mem_rd;
  logic          mem_wr;
  logic          mem_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_valid;

  logic [7:0]  mem [0:255];
  logic [7:0]  img [0:255];
  logic [7:0]  out_q [$];
  logic [15:0] wr_q [$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int first_rd_cyc = -1;
  int first_ov_cyc = -1;
  int wr_cycles = 0;
  int pc_w = 0;

  nanop_core #(.DW(DW), .AW(AW)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .mem_addr_o  (mem_addr),
    .mem_rdata_i (mem_rdata),
    .mem_wdata_o (mem_wdata),
    .mem_rd_o    (mem_rd),
    .mem_wr_o    (mem_wr),
    .mem_ready_i (mem_ready),
    .out_data_o  (out_data),
    .out_valid_o (out_valid)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Memory write port: commits at the edge where the write handshake completes.
  initial begin
    forever begin
      @(posedge clk);
      if (!reset && mem_wr && mem_ready) mem[mem_addr] = mem_wdata;
    end
  end

  // Output monitor, sampled on the falling edge.
  initial begin
    logic [17:0] prev_bus;
    logic        prev_wait;
    logic        prev_ov;
    logic [7:0]  exp_o;
    logic [15:0] exp_w;
    prev_bus  = '0;
    prev_wait = 1'b0;
    prev_ov   = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        prev_wait    = 1'b0;
        prev_ov      = 1'b0;
        first_rd_cyc = -1;
        first_ov_cyc = -1;
      end else begin
        check_eq("rd_wr_excl", 32'(mem_rd & mem_wr), 32'd0);
        if (prev_wait)
          check_eq("hold_stable", 32'({mem_addr, mem_wdata, mem_rd, mem_wr}), 32'(prev_bus));
        if (mem_rd && first_rd_cyc < 0) first_rd_cyc = cyc;
        if (out_valid) begin
          check_eq("ov_pulse", 32'(prev_ov), 32'd0);
          if (first_ov_cyc < 0) first_ov_cyc = cyc;
          check_eq("out_expected", 32'(out_q.size() > 0), 32'd1);
          if (out_q.size() > 0) begin
            exp_o = out_q.pop_front();
            $display("out   data=0x%02h exp=0x%02h cyc=%0d", out_data, exp_o, cyc);
            check_eq("out_data", 32'(out_data), 32'(exp_o));
          end
        end
        if (mem_wr && mem_ready) begin
          check_eq("wr_expected", 32'(wr_q.size() > 0), 32'd1);
          if (wr_q.size() > 0) begin
            exp_w = wr_q.pop_front();
            $display("write addr=0x%02h data=0x%02h exp=0x%04h cyc=%0d", mem_addr, mem_wdata, exp_w, cyc);
            check_eq("wr_beat", 32'({mem_addr, mem_wdata}), 32'(exp_w));
          end
        end
        if (mem_wr && mem_addr == 8'h20 && mem_wdata == 8'hA5) wr_cycles++;
        prev_wait = (mem_rd | mem_wr) & ~mem_ready;
        prev_bus  = {mem_addr, mem_wdata, mem_rd, mem_wr};
        prev_ov   = out_valid;
      end
    end
  end

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
    pc_w = 0;
  endtask

  task automatic emit(input logic [7:0] op, input logic [7:0] opd);
    img[pc_w]     = op;
    img[pc_w + 1] = opd;
    pc_w += 2;
  endtask

  task automatic halt();
    emit(8'd13, 8'(pc_w));
  endtask

  task automatic boot();
    @(posedge clk);
    #2 reset = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = img[i];
    wr_cycles = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((out_q.size() != 0 || wr_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_timeout", 32'(out_q.size() + wr_q.size()), 32'd0);
    repeat (12) @(negedge clk);
    out_q.delete();
    wr_q.delete();
  endtask

  task automatic wait_wr_start(input int budget);
    int n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!mem_wr && n < budget);
    check_eq("sta_seen", 32'(mem_wr), 32'd1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_rd"},    32'(mem_rd),    32'd0);
    check_eq({pfx, "_wr"},    32'(mem_wr),    32'd0);
    check_eq({pfx, "_addr"},  32'(mem_addr),  32'd0);
    check_eq({pfx, "_wdata"}, 32'(mem_wdata), 32'd0);
    check_eq({pfx, "_out"},   32'(out_data),  32'd0);
    check_eq({pfx, "_ov"},    32'(out_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    #1 reset = 1'b1;
    #1 check_reset_outputs("rst0");

    // LDA/ADD/OUT with carry out; flags then steer JNC (not taken) and JNZ (taken).
    clear_img();
    emit(8'd10, 8'h10); emit(8'd4, 8'h11); emit(8'd12, 8'h00);
    emit(8'd14, 8'h30); emit(8'd15, 8'h38); halt();
    pc_w = 8'h30; emit(8'd10, 8'h12); emit(8'd12, 8'h00); halt();
    pc_w = 8'h38; emit(8'd10, 8'h13); emit(8'd12, 8'h00); halt();
    img[8'h10] = 8'hF0; img[8'h11] = 8'h20; img[8'h12] = 8'hEE; img[8'h13] = 8'h5A;
    out_q.push_back(8'h10); out_q.push_back(8'h5A);
    boot();
    wait_idle(400);
    check_eq("first_fetch_cyc", 32'(first_rd_cyc > 0), 32'd1);
    check_eq("add_prog_latency", 32'(first_ov_cyc - first_rd_cyc), 32'd9);

    // SUB to zero: JNZ falls through, JNC branches to 0x40.
    clear_img();
    emit(8'd10, 8'h20); emit(8'd6, 8'h20); emit(8'd15, 8'h40); emit(8'd12, 8'h00);
    emit(8'd14, 8'h40); emit(8'd10, 8'h22); emit(8'd12, 8'h00); halt();
    pc_w = 8'h40; emit(8'd10, 8'h21); emit(8'd12, 8'h00); halt();
    img[8'h20] = 8'h05; img[8'h21] = 8'h77; img[8'h22] = 8'hEE;
    out_q.push_back(8'h00); out_q.push_back(8'h77);
    boot();
    wait_idle(400);

    // Logic ops and carry/borrow chains.
    clear_img();
    emit(8'd10, 8'h80); emit(8'd1, 8'h81); emit(8'd12, 8'h00);
    emit(8'd2, 8'h82);  emit(8'd12, 8'h00);
    emit(8'd3, 8'h81);  emit(8'd12, 8'h00);
    emit(8'd4, 8'h83);  emit(8'd5, 8'h84); emit(8'd12, 8'h00);
    emit(8'd6, 8'h83);  emit(8'd7, 8'h85); emit(8'd12, 8'h00);
    emit(8'd7, 8'h85);  emit(8'd12, 8'h00); halt();
    img[8'h80] = 8'h3C; img[8'h81] = 8'h0F; img[8'h82] = 8'hF0;
    img[8'h83] = 8'hC8; img[8'h84] = 8'h50; img[8'h85] = 8'h01;
    out_q.push_back(8'h33); out_q.push_back(8'h30); out_q.push_back(8'h3F);
    out_q.push_back(8'h58); out_q.push_back(8'h8E); out_q.push_back(8'h8D);
    boot();
    wait_idle(600);

    // Rotates through carry; JNC confirms carry is clear afterwards.
    clear_img();
    emit(8'd10, 8'h90); emit(8'd8, 8'h00); emit(8'd12, 8'h00);
    emit(8'd9, 8'h00);  emit(8'd12, 8'h00); emit(8'd14, 8'h50);
    emit(8'd10, 8'h92); emit(8'd12, 8'h00); halt();
    pc_w = 8'h50; emit(8'd10, 8'h91); emit(8'd12, 8'h00); halt();
    img[8'h90] = 8'h81; img[8'h91] = 8'h66; img[8'h92] = 8'hEE;
    out_q.push_back(8'h02); out_q.push_back(8'h81); out_q.push_back(8'h66);
    boot();
    wait_idle(400);

    // STA held off by three wait states, then read back.
    clear_img();
    emit(8'd10, 8'h90); emit(8'd11, 8'h20); emit(8'd10, 8'h20); emit(8'd12, 8'h00); halt();
    img[8'h90] = 8'hA5;
    wr_q.push_back(16'h20A5); out_q.push_back(8'hA5);
    boot();
    wait_wr_start(100);
    mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 mem_ready = 1'b1;
    wait_idle(400);
    check_eq("sta_hold_cycles", 32'(wr_cycles), 32'd4);

    // JMP to 0xFE: NOP occupies 0xFE/0xFF and fetch wraps to 0x00.
    clear_img();
    emit(8'd13, 8'hFE);
    boot();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mem_rd && mem_addr == 8'hFE) && n < 100);
    check_eq("wrap_fetch_fe", 32'({mem_rd, mem_addr}), 32'h1FE);
    @(negedge clk);
    check_eq("wrap_fetch_ff", 32'({mem_rd, mem_addr}), 32'h1FF);
    @(negedge clk);
    check_eq("wrap_nop_noreq", 32'({mem_rd, mem_wr}), 32'd0);
    @(negedge clk);
    check_eq("wrap_fetch_00", 32'({mem_rd, mem_addr}), 32'h100);
    wait_idle(10);

    // Reset while a STA is stalled: the write is abandoned, fetch restarts at 0.
    clear_img();
    emit(8'd10, 8'h90); emit(8'd12, 8'h00); emit(8'd11, 8'h20); halt();
    img[8'h90] = 8'hA5; img[8'h20] = 8'h33;
    out_q.push_back(8'hA5);
    boot();
    wait_wr_start(100);
    mem_ready = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_reset_outputs("rst_sta");
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_no_write", 32'(mem[8'h20]), 32'h33);
    out_q.push_back(8'hA5);
    wr_q.push_back(16'h20A5);
    reset = 1'b0;
    @(negedge clk);
    check_eq("restart_fetch", 32'({mem_rd, mem_addr}), 32'h100);
    wait_idle(400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nanop_core.md
NANOP_CORE -- requirements
Module: nanop_core

Interface
REQ-001 Parameter DW, default 8: data/instruction word width; SHALL be >= 4.
REQ-002 Parameter AW, default 8: address width; SHALL be <= DW.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 mem_addr  out  AW  memory address.
REQ-006 mem_rdata  in  DW  read data, sampled at the completing edge.
REQ-007 mem_wdata  out  DW  write data (accumulator).
REQ-008 mem_rd  out  1  read request.
REQ-009 mem_wr  out  1  write request.
REQ-010 mem_ready  in  1  access completes at an edge where request and mem_ready are both 1.
REQ-011 out_data  out  DW  value captured by OUT.
REQ-012 out_valid  out  1  one-cycle pulse when out_data updates.

Function
REQ-013 Instruction format SHALL be two consecutive words: opcode word (opcode = bits [3:0], upper bits ignored), then operand word (address = bits [AW-1:0]).
REQ-014 Opcodes SHALL be: 0 NOP, 1 XOR, 2 AND, 3 OR, 4 ADD, 5 ADC, 6 SUB, 7 SBC, 8 ROL, 9 ROR, 10 LDA, 11 STA, 12 OUT, 13 JMP, 14 JNC, 15 JNZ; no undefined codes.
REQ-015 FSM states SHALL be FETCH_I, FETCH_A, EXEC; FETCH_I -> FETCH_A -> EXEC -> FETCH_I, each transition only when that state's memory access (if any) completes.
REQ-016 FETCH_I: mem_rd=1, mem_addr=PC; on completion load I, PC <= PC+1.
REQ-017 FETCH_A: mem_rd=1, mem_addr=PC; on completion load address register, PC <= PC+1.
REQ-018 EXEC for ALU ops and LDA: mem_rd=1, mem_addr=address register; result written on completion.
REQ-019 EXEC for STA: mem_wr=1, mem_addr=address register, mem_wdata=Acc.
REQ-020 EXEC for NOP, ROL, ROR, OUT, JMP, JNC, JNZ: no memory request; lasts exactly one cycle.
REQ-021 mem_addr, mem_wdata, mem_rd, mem_wr SHALL stay stable while waiting for mem_ready; mem_rd and mem_wr never both 1.
REQ-022 With mem_ready tied 1: memory-accessing instruction = 3 cycles; other instructions = 3 cycles (third with no request).
REQ-023 PC arithmetic SHALL be modulo 2^AW; increment from 2^AW-1 gives 0.
REQ-024 Arithmetic modulo 2^DW; ADD: Acc<=Acc+M, C<=carry-out; ADC: Acc<=Acc+M+C, C<=carry-out.
REQ-025 SUB: Acc<=Acc-M, C<=borrow (1 iff Acc<M unsigned); SBC: Acc<=Acc-M-C, C<=borrow.
REQ-026 XOR/AND/OR/LDA: Acc<=result, C unchanged.
REQ-027 ROL: {C,Acc}<={Acc,C}; ROR: {Acc,C}<={C,Acc}.
REQ-028 Z SHALL be set to (new Acc == 0) by every Acc-writing instruction; unchanged by NOP, STA, OUT, jumps.
REQ-029 OUT: out_data<=Acc; out_valid=1 for exactly the following cycle.
REQ-030 JMP: PC<=address; JNC: PC<=address iff C==0; JNZ: PC<=address iff Z==0; otherwise PC unchanged.

Reset
REQ-031 reset=1 SHALL immediately (without clk) force: state=FETCH_I, PC=0, I=0, address register=0, Acc=0, C=0, Z=0, out_data=0, out_valid=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0.
REQ-032 Reset asserted mid-access SHALL abort the access; no write occurs after reset assertion.
REQ-033 After reset release, first rising edge SHALL begin FETCH_I at address 0 (mem_rd=1).

Verification
REQ-034 mem_ready=1; program LDA 0x10, ADD 0x11, OUT; mem[0x10]=0xF0, mem[0x11]=0x20 -> out_data=0x10, C=1, Z=0, out_valid one cycle, 9 cycles total.
REQ-035 mem_ready=1; Acc=0x05 via LDA, SUB of 0x05 -> Acc=0x00, Z=1, C=0; then JNZ 0x40 not taken (PC=next), JNC 0x40 taken (PC=0x40).
REQ-036 mem_ready held 0 for 3 cycles during STA of Acc=0xA5 to 0x20 -> mem_wr, mem_addr=0x20, mem_wdata=0xA5 stable 4 cycles; single write of 0xA5.
REQ-037 Acc=0x81, C=0; ROL -> Acc=0x02, C=1; ROR -> Acc=0x81, C=0.
REQ-038 JMP 0xFE placing a NOP at 0xFE/0xFF -> fetch continues at 0x00 (PC wrap).
REQ-039 Assert reset during waiting STA (mem_ready=0) -> mem_wr drops same cycle, all outputs at REQ-031 values, no write; after release fetch restarts at 0x00.
